pc_fetch_unit: RTL and testbench

Program-counter and fetch-redirect unit at the front of the pipeline. It loads the reset vector from instruction memory after reset and advances the PC by one or two 16-bit words per cycle. It accepts the branch decision (`taken`, target `pc`) produced by the jumps control unit, redirects fetch, and issues a counted flush to the IF/ID and ID/EX pipeline registers. It is the consumer end of the jump-resolution interface.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/flush_counter.sv | 26 ++
 rtl/pc_fetch_unit.sv | 89 ++++++++
 tb/tb_pc_fetch_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, datapath widths and
// the default imem locations of the reset vector.
package cpu_pkg;

   localparam int unsigned PC_W = 32;
   localparam int unsigned IW   = 16;
   localparam int unsigned FC_W = 3;

   localparam logic [PC_W-1:0] VEC_HI_ADDR_DEF = 32'd0;
   localparam logic [PC_W-1:0] VEC_LO_ADDR_DEF = 32'd1;

   typedef enum logic [1:0] {
      VEC_HI = 2'd0,
      VEC_LO = 2'd1,
      RUN    = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/flush_counter.sv
// Load/decrement counter that saturates at zero; busy while nonzero.
// A load always wins over the decrement, so reloads never accumulate.
module flush_counter #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         busy
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign busy = (count != '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch-redirect unit: two-cycle reset-vector load from imem,
// then sequential advance by 1/2 words, taken-branch redirect with counted flush.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned      FLUSH_CYCLES = 2,
   parameter logic [PC_W-1:0]  VEC_HI_ADDR  = VEC_HI_ADDR_DEF,
   parameter logic [PC_W-1:0]  VEC_LO_ADDR  = VEC_LO_ADDR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            taken,
   input  logic [PC_W-1:0] target_pc,
   input  logic            stall,
   input  logic            two_word,
   input  logic [IW-1:0]   imem_data,
   output logic [PC_W-1:0] imem_addr,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            flush
);

   localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES);

   fetch_state_t    state, state_nx;
   logic [PC_W-1:0] pc_nx;
   logic [IW-1:0]   vec_hi, vec_hi_nx;
   logic            flush_load;
   logic            flush_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= VEC_HI;
         pc     <= '0;
         vec_hi <= '0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         vec_hi <= vec_hi_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      vec_hi_nx   = vec_hi;
      imem_addr   = pc;
      fetch_valid = 1'b0;
      flush_load  = 1'b0;
      case (state)
         VEC_HI: begin
            imem_addr = VEC_HI_ADDR;
            vec_hi_nx = imem_data;
            state_nx  = VEC_LO;
         end
         VEC_LO: begin
            imem_addr = VEC_LO_ADDR;
            pc_nx     = {vec_hi, imem_data};
            state_nx  = RUN;
         end
         RUN: begin
            fetch_valid = 1'b1;
            if (taken) begin
               pc_nx      = target_pc;
               flush_load = 1'b1;
            end else if (!stall) begin
               pc_nx = pc + (two_word ? PC_W'(2) : PC_W'(1));
            end
         end
         default: state_nx = VEC_HI;
      endcase
      // Reset is synchronous, so force the reset-time outputs while it is held.
      if (rst) begin
         imem_addr   = VEC_HI_ADDR;
         fetch_valid = 1'b0;
      end
   end

   flush_counter #(.W(FC_W)) u_flush_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (flush_load),
      .load_val (FLUSH_LOAD),
      .busy     (flush_busy)
   );

   assign flush = flush_busy & ~rst;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a two-word behavioural imem.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        taken;
   logic [31:0] target_pc;
   logic        stall;
   logic        two_word;
   logic [15:0] imem_data;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        flush;

   logic [15:0] vec_hi_word;
   logic [15:0] vec_lo_word;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   pc_fetch_unit #(.FLUSH_CYCLES(2), .VEC_HI_ADDR(32'd0), .VEC_LO_ADDR(32'd1)) dut (
      .clk         (clk),
      .rst         (rst),
      .taken       (taken),
      .target_pc   (target_pc),
      .stall       (stall),
      .two_word    (two_word),
      .imem_data   (imem_data),
      .imem_addr   (imem_addr),
      .pc          (pc),
      .fetch_valid (fetch_valid),
      .flush       (flush)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (imem_addr == 32'd0)
         imem_data = vec_hi_word;
      else if (imem_addr == 32'd1)
         imem_data = vec_lo_word;
      else
         imem_data = imem_addr[15:0] ^ 16'hA5A5;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; taken = 1'b0; target_pc = '0; stall = 1'b0; two_word = 1'b0;
      vec_hi_word = 16'h0000; vec_lo_word = 16'h0040;
      step(); step();
      check("rst_fv", {31'd0, fetch_valid}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_pc", pc, 32'd0);

      // Vector fetch
      rst = 1'b0; taken = 1'b1; target_pc = 32'h0000_0777; stall = 1'b1;
      check("vh_addr", imem_addr, 32'd0);
      check("vh_fv", {31'd0, fetch_valid}, 32'd0);
      step();
      check("vl_addr", imem_addr, 32'd1);
      check("vl_fv", {31'd0, fetch_valid}, 32'd0);
      taken = 1'b0; stall = 1'b0;
      step();
      check("vec_pc", pc, 32'h0000_0040);
      check("vec_fv", {31'd0, fetch_valid}, 32'd1);
      check("vec_addr", imem_addr, 32'h0000_0040);
      check("vec_flush", {31'd0, flush}, 32'd0);

      // Sequential advance 0,1,0
      two_word = 1'b0; step(); check("seq1", pc, 32'h41);
      two_word = 1'b1; step(); check("seq2", pc, 32'h43);
      two_word = 1'b0; step(); check("seq3", pc, 32'h44);

      // Stall holds the PC
      stall = 1'b1; step(); check("stall_pc", pc, 32'h44);
      stall = 1'b0;

      // Move to 0x50, let that flush drain with stall high
      taken = 1'b1; target_pc = 32'h50; step();
      check("r50_pc", pc, 32'h50);
      check("r50_fl0", {31'd0, flush}, 32'd1);
      taken = 1'b0; stall = 1'b1; step();
      check("r50_fl1", {31'd0, flush}, 32'd1);
      step();
      check("r50_fl2", {31'd0, flush}, 32'd0);
      check("r50_hold", pc, 32'h50);

      // Redirect beats stall
      taken = 1'b1; target_pc = 32'h200; stall = 1'b1; step();
      check("rbs_pc", pc, 32'h200);
      check("rbs_fl0", {31'd0, flush}, 32'd1);
      taken = 1'b0; step();
      check("rbs_fl1", {31'd0, flush}, 32'd1);
      check("rbs_hold", pc, 32'h200);
      step();
      check("rbs_fl2", {31'd0, flush}, 32'd0);

      // Back-to-back redirects
      stall = 1'b0; taken = 1'b1; target_pc = 32'h300; step();
      check("b2b_pc1", pc, 32'h300);
      check("b2b_fl0", {31'd0, flush}, 32'd1);
      target_pc = 32'h400; step();
      check("b2b_pc2", pc, 32'h400);
      check("b2b_fl1", {31'd0, flush}, 32'd1);
      taken = 1'b0; two_word = 1'b0; step();
      check("b2b_fl2", {31'd0, flush}, 32'd1);
      check("b2b_pc3", pc, 32'h401);
      step();
      check("b2b_fl3", {31'd0, flush}, 32'd0);
      check("b2b_pc4", pc, 32'h402);

      // Wrap-around
      taken = 1'b1; target_pc = 32'hFFFF_FFFF; step();
      check("wrap_tgt", pc, 32'hFFFF_FFFF);
      taken = 1'b0; two_word = 1'b1; step();
      check("wrap2", pc, 32'h0000_0001);
      taken = 1'b1; target_pc = 32'hFFFF_FFFF; step();
      taken = 1'b0; two_word = 1'b0; step();
      check("wrap1", pc, 32'h0000_0000);

      // Reset mid-flush, new vector 0x0001_1234
      vec_hi_word = 16'h0001; vec_lo_word = 16'h1234;
      taken = 1'b1; target_pc = 32'h1234_0000; step();
      check("mf_flush", {31'd0, flush}, 32'd1);
      rst = 1'b1; target_pc = 32'h999; step();
      check("mf_rst_flush", {31'd0, flush}, 32'd0);
      check("mf_rst_pc", pc, 32'd0);
      check("mf_rst_addr", imem_addr, 32'd0);
      check("mf_rst_fv", {31'd0, fetch_valid}, 32'd0);
      rst = 1'b0;
      check("mf_vh_addr", imem_addr, 32'd0);
      step();
      check("mf_vl_addr", imem_addr, 32'd1);
      check("mf_vl_pc", pc, 32'd0);
      check("mf_vl_flush", {31'd0, flush}, 32'd0);
      step();
      check("mf_vec_pc", pc, 32'h0001_1234);
      check("mf_vec_fv", {31'd0, fetch_valid}, 32'd1);
      check("mf_vec_flush", {31'd0, flush}, 32'd0);
      step();
      check("mf_run_tk", pc, 32'h999);
      check("mf_run_fl", {31'd0, flush}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
